// File: rtl/vec_pipe_pkg.sv
// rtl/vec_pipe_pkg.sv - shared lane/occupancy types for the vector pipeline stages
package vec_pipe_pkg;

    localparam int DEFAULT_WIDTH = 18;
    localparam int DEFAULT_LANES = 4;

    typedef logic [DEFAULT_WIDTH-1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Encoding doubles as the stored-entry count.
    function automatic logic [1:0] occ_count(input occ_state_t s);
        return logic'(s == FULL) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// rtl/pipe_stage_elastic_entry.sv - one stored pipeline entry: lane data, lane mask, valid
module pipe_entry
    import vec_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] load_data,
    input  logic [LANES-1:0]       load_mask,
    output logic [LANES*WIDTH-1:0] data,
    output logic [LANES-1:0]       mask,
    output logic                   valid
);

    // Clear only drops valid; payload keeps stale contents until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            mask  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            mask  <= load_mask;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready stage register with 2-entry skid buffer
module pipe_stage_elastic
    import vec_pipe_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int LANES         = DEFAULT_LANES,
    parameter bit ZERO_INACTIVE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_mask,
    output logic [1:0]             occupancy
);

    occ_state_t state_q, state_d;

    logic                   accept, deliver;
    logic                   main_load, main_clear, main_from_skid;
    logic                   skid_load, skid_clear;
    logic [LANES*WIDTH-1:0] main_data, skid_data, main_load_data;
    logic [LANES-1:0]       main_mask, skid_mask, main_load_mask;
    logic                   main_valid, skid_valid;

    // in_ready is a pure register output, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign occupancy = occ_count(state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (deliver) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_load_data = main_from_skid ? skid_data : in_data;
    assign main_load_mask = main_from_skid ? skid_mask : in_mask;

    pipe_entry #(.WIDTH(WIDTH), .LANES(LANES)) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_load_data),
        .load_mask (main_load_mask),
        .data      (main_data),
        .mask      (main_mask),
        .valid     (main_valid)
    );

    pipe_entry #(.WIDTH(WIDTH), .LANES(LANES)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_mask (in_mask),
        .data      (skid_data),
        .mask      (skid_mask),
        .valid     (skid_valid)
    );

    // Inactive-lane zeroing is output-only; stored payload is untouched.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign out_data[i*WIDTH +: WIDTH] =
            (ZERO_INACTIVE && !main_mask[i]) ? '0 : main_data[i*WIDTH +: WIDTH];
    end
    assign out_mask = main_mask;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed-vector and scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;
    import vec_pipe_pkg::*;

    localparam int W  = 18;
    localparam int L  = 4;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [L-1:0]  in_mask;
    logic          in_ready, out_valid, in_ready_nz, out_valid_nz;
    logic [DW-1:0] out_data, out_data_nz;
    logic [L-1:0]  out_mask, out_mask_nz;
    logic [1:0]    occupancy, occupancy_nz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(W), .LANES(L), .ZERO_INACTIVE(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
        .occupancy(occupancy)
    );

    pipe_stage_elastic #(.WIDTH(W), .LANES(L), .ZERO_INACTIVE(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_nz), .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid_nz), .out_ready(out_ready), .out_data(out_data_nz), .out_mask(out_mask_nz),
        .occupancy(occupancy_nz)
    );

    typedef struct {
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic [L-1:0]  m;
        logic          ordy;
        logic          e_ov;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic [DW-1:0] e_od;
        logic [DW-1:0] e_od_nz;
        logic [L-1:0]  e_om;
    } vec_t;

    function automatic logic [DW-1:0] pack4(input lane_t a, input lane_t b, input lane_t c, input lane_t d);
        return {d, c, b, a};
    endfunction

    function automatic logic [DW-1:0] dv(input int n);
        lane_t base = lane_t'(n);
        return pack4(base, base + 18'd1, base + 18'd2, base + 18'd3);
    endfunction

    function automatic logic [DW-1:0] zmask(input logic [DW-1:0] d, input logic [L-1:0] m);
        logic [DW-1:0] r = d;
        for (int i = 0; i < L; i++) if (!m[i]) r[i*W +: W] = '0;
        return r;
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] d, input logic [L-1:0] m,
                                input logic ordy, input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                                input logic [DW-1:0] e_od, input logic [DW-1:0] e_od_nz, input logic [L-1:0] e_om);
        vec_t v;
        v.flush = fl; v.iv = iv; v.d = d; v.m = m; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_od = e_od; v.e_od_nz = e_od_nz; v.e_om = e_om;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t            tbl[15];
    logic [DW+L-1:0] sb[$];
    logic [DW-1:0]   ma, pa, prev_od, exp_d;
    logic [L-1:0]    prev_om, exp_m;
    logic [95:0]     rnd;
    logic            stall_prev, fl, ir0;

    initial begin
        ma = pack4(18'h11, 18'h22, 18'h33, 18'h44);
        pa = pack4(18'h11, 18'h0, 18'h33, 18'h0);
        //        fl   iv   data   mask  ordy ov   ir   occ   od     od_nz  om
        tbl[0]  = mk(1'b0, 1'b1, dv(1), 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, dv(1), dv(1), 4'hF);
        tbl[1]  = mk(1'b0, 1'b1, dv(2), 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, dv(1), dv(1), 4'hF);
        tbl[2]  = mk(1'b0, 1'b1, dv(3), 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, dv(1), dv(1), 4'hF);
        tbl[3]  = mk(1'b0, 1'b1, dv(3), 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, dv(2), dv(2), 4'hF);
        tbl[4]  = mk(1'b0, 1'b1, dv(3), 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, dv(2), dv(2), 4'hF);
        tbl[5]  = mk(1'b0, 1'b0, dv(9), 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, dv(3), dv(3), 4'hF);
        tbl[6]  = mk(1'b0, 1'b0, dv(9), 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, '0, '0, '0);
        tbl[7]  = mk(1'b0, 1'b1, dv(4), 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, dv(4), dv(4), 4'hF);
        tbl[8]  = mk(1'b0, 1'b1, dv(5), 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, dv(5), dv(5), 4'hF);
        tbl[9]  = mk(1'b1, 1'b1, dv(6), 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, '0, '0, '0);
        tbl[10] = mk(1'b0, 1'b0, dv(6), 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, '0, '0, '0);
        tbl[11] = mk(1'b0, 1'b1, ma,    4'h5, 1'b0, 1'b1, 1'b1, 2'd1, pa,    ma,    4'h5);
        tbl[12] = mk(1'b0, 1'b1, dv(7), 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, pa,    ma,    4'h5);
        tbl[13] = mk(1'b1, 1'b0, dv(8), 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, '0, '0, '0);
        tbl[14] = mk(1'b0, 1'b0, dv(8), 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, '0, '0, '0);

        do_reset();
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(1'b1));
        check("rst_occupancy", 128'(occupancy), 128'(2'd0));
        check("rst_out_data",  128'(out_data),  128'(0));
        check("rst_out_mask",  128'(out_mask),  128'(0));

        for (int i = 0; i < 15; i++) begin
            flush = tbl[i].flush; in_valid = tbl[i].iv; in_data = tbl[i].d;
            in_mask = tbl[i].m; out_ready = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            check($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(tbl[i].e_ir));
            check($sformatf("vec%0d_occupancy", i), 128'(occupancy), 128'(tbl[i].e_occ));
            if (tbl[i].e_ov) begin
                check($sformatf("vec%0d_out_data", i),    128'(out_data),    128'(tbl[i].e_od));
                check($sformatf("vec%0d_out_mask", i),    128'(out_mask),    128'(tbl[i].e_om));
                check($sformatf("vec%0d_out_data_nz", i), 128'(out_data_nz), 128'(tbl[i].e_od_nz));
                check($sformatf("vec%0d_out_mask_nz", i), 128'(out_mask_nz), 128'(tbl[i].e_om));
            end
        end

        // Streaming at full rate
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = pack4(lane_t'(k), lane_t'(k), lane_t'(k), lane_t'(k));
            in_mask = 4'hF; out_ready = 1'b1;
            tick();
            check($sformatf("stream%0d_out_valid", k), 128'(out_valid), 128'(1'b1));
            check($sformatf("stream%0d_out_data", k),  128'(out_data),
                  128'(pack4(lane_t'(k), lane_t'(k), lane_t'(k), lane_t'(k))));
            check($sformatf("stream%0d_in_ready", k),  128'(in_ready),  128'(1'b1));
            check($sformatf("stream%0d_occupancy", k), 128'(occupancy), 128'(2'd1));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_out_valid", 128'(out_valid), 128'(1'b0));
        check("stream_drain_occupancy", 128'(occupancy), 128'(2'd0));

        // Asynchronous reset while FULL
        do_reset();
        in_valid = 1'b1; in_data = {L{18'h3FFFF}}; in_mask = 4'hF; out_ready = 1'b0;
        tick();
        tick();
        check("full_occupancy", 128'(occupancy), 128'(2'd2));
        check("full_out_data",  128'(out_data),  128'({L{18'h3FFFF}}));
        #2 reset = 1'b1;
        #1;
        check("async_rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("async_rst_out_data",  128'(out_data),  128'(0));
        check("async_rst_in_ready",  128'(in_ready),  128'(1'b1));
        check("async_rst_occupancy", 128'(occupancy), 128'(2'd0));
        in_valid = 1'b0;
        #1 reset = 1'b0;
        tick();
        check("post_rst_out_valid", 128'(out_valid), 128'(1'b0));
        in_valid = 1'b1; in_data = dv(40); in_mask = 4'hF;
        tick();
        check("post_rst_accept_data", 128'(out_data), 128'(dv(40)));
        check("post_rst_occupancy",   128'(occupancy), 128'(2'd1));

        // Random traffic against a scoreboard FIFO
        do_reset();
        sb.delete();
        stall_prev = 1'b0;
        prev_od = '0;
        prev_om = '0;
        for (int c = 0; c < 10000; c++) begin
            fl = ($urandom_range(0, 49) == 0);
            flush = fl;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            rnd = {$urandom(), $urandom(), $urandom()};
            in_data = rnd[DW-1:0];
            in_mask = 4'($urandom_range(0, 15));
            #1;
            ir0 = in_ready;
            out_ready = !out_ready;
            #1;
            check("rand_in_ready_comb", 128'(in_ready), 128'(ir0));
            out_ready = !out_ready;
            #1;
            if (stall_prev) begin
                check("rand_stall_data", 128'(out_data), 128'(prev_od));
                check("rand_stall_mask", 128'(out_mask), 128'(prev_om));
            end
            if (fl) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("rand_deliver_unexpected", 128'(1'b1), 128'(1'b0));
                    end else begin
                        {exp_m, exp_d} = sb.pop_front();
                        check("rand_out_data",    128'(out_data),    128'(zmask(exp_d, exp_m)));
                        check("rand_out_mask",    128'(out_mask),    128'(exp_m));
                        check("rand_out_data_nz", 128'(out_data_nz), 128'(exp_d));
                    end
                end
                if (in_valid && in_ready) sb.push_back({in_mask, in_data});
            end
            stall_prev = !fl && out_valid && !out_ready;
            prev_od = out_data;
            prev_om = out_mask;
            tick();
            check("rand_occupancy", 128'(occupancy), 128'(sb.size()));
            check("rand_out_valid", 128'(out_valid), 128'(sb.size() != 0));
            check("rand_in_ready",  128'(in_ready),  128'(sb.size() < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
